// File: rtl/sw_ctrl_pkg.sv
// Shared constants and types for the slide-switch input controller:
// register addresses, status bit positions and the operand FSM state type.
package sw_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    localparam int STAT_OP_VALID = 0;
    localparam int STAT_OVERFLOW = 1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } op_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch lane: two-flop synchroniser, sample history and debounced level.
// The history advances only on the shared sample_tick from the top-level prescaler.
module sw_debounce_bit
    import sw_ctrl_pkg::*;
#(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic sample_tick,
    output logic deb
);

    logic [1:0]             sync;
    logic [DEB_SAMPLES-1:0] hist;
    logic [DEB_SAMPLES-1:0] hist_next;

    // Decide on the history including the sample being shifted in this cycle.
    assign hist_next = {hist[DEB_SAMPLES-2:0], sync[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            hist <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sample_tick) begin
                hist <= hist_next;
                if (&hist_next) begin
                    deb <= 1'b1;
                end else if (~|hist_next) begin
                    deb <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sw_input_controller.sv
// Avalon-MM slave for the slide-switch bank: debounce, maskable edge IRQ and GO-launched operand handshake.
// Build option SW_BOTH_EDGES_EN: edge_capture also latches falling debounced edges (GO launch stays rising-only).
module sw_input_controller
    import sw_ctrl_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int GO_BIT      = 9,
    parameter int SAMPLE_DIV  = 50000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_port,
    input  logic [1:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              op_valid,
    output logic [GO_BIT-1:0] op_data,
    input  logic              op_ready
);

    localparam int PW = $clog2(SAMPLE_DIV);

    logic [PW-1:0]    presc;
    logic             sample_tick;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [31:0]      read_mux;
    logic             overflow;
    logic             ovf_set;
    logic             ovf_clr;
    logic             go_rise;
    logic             load_op;
    op_state_t        state;
    op_state_t        state_next;
    logic             unused_writedata;

    assign unused_writedata = ^writedata[31:WIDTH];

    assign sample_tick = (presc == PW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (sample_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        sw_debounce_bit #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk         (clk),
            .reset       (reset),
            .raw         (in_port[i]),
            .sample_tick (sample_tick),
            .deb         (deb[i])
        );
    end

`ifdef SW_BOTH_EDGES_EN
    assign edge_set = deb ^ deb_q;
`else
    assign edge_set = deb & ~deb_q;
`endif

    assign go_rise  = deb[GO_BIT] & ~deb_q[GO_BIT];
    assign edge_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign ovf_clr  = write && (address == ADDR_STATUS) && writedata[STAT_OVERFLOW];
    assign irq      = |(edge_capture & irq_mask);
    assign op_valid = (state == PEND);

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:   read_mux[WIDTH-1:0] = deb;
            ADDR_MASK:   read_mux[WIDTH-1:0] = irq_mask;
            ADDR_STATUS: begin
                read_mux[STAT_OVERFLOW] = overflow;
                read_mux[STAT_OP_VALID] = op_valid;
            end
            default:     read_mux[WIDTH-1:0] = edge_capture;
        endcase
    end

    // Set terms are OR-ed after the clear so a coincident set always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q        <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            deb_q        <= deb;
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
            if (write && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            readdata <= read_mux;
        end
    end

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            IDLE: begin
                if (go_rise) begin
                    load_op    = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (op_ready) begin
                    state_next = IDLE;
                end
                if (go_rise) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_data  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (load_op) begin
                op_data <= deb[GO_BIT-1:0];
            end
            overflow <= (overflow & ~ovf_clr) | ovf_set;
        end
    end

endmodule

// File: tb/tb_sw_input_controller.sv
// Directed self-checking bench for sw_input_controller with a fast prescaler (SAMPLE_DIV=4, DEB_SAMPLES=4).
// Expectations for the optional edge mode follow SW_BOTH_EDGES_EN when it is defined for the build.
module tb_sw_input_controller;
    import sw_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  in_port;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        op_valid;
    logic [8:0]  op_data;
    logic        op_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sw_input_controller #(
        .WIDTH       (10),
        .GO_BIT      (9),
        .SAMPLE_DIV  (4),
        .DEB_SAMPLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_port   (in_port),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; sample ticks land on edges where cyc is a multiple of 4.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] val, input int cycles);
        in_port = val;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        write     = 1'b1;
        address   = addr;
        writedata = data;
        @(negedge clk);
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        address = addr;
        @(negedge clk);
        data = readdata;
    endtask

    task automatic ready_pulse(input string tag);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        checkOutput(tag, 32'(op_valid), 32'd0);
    endtask

    // Change inputs just before an edge two cycles ahead of a sample tick, so the
    // debounced rise lands on edge c0+15 and the edge/overflow set on edge c0+16;
    // the bus write is placed on exactly that edge.
    task automatic timed_change(input logic [9:0] val, input logic [1:0] addr, input logic [31:0] data);
        int c0;
        for (int k = 0; k < 4 && (cyc % 4) != 1; k++) @(negedge clk);
        c0 = cyc;
        in_port = val;
        for (int k = 0; k < 20 && cyc < c0 + 15; k++) @(negedge clk);
        bus_write(addr, data);
    endtask

    localparam int SETTLE = 24;

    initial begin
        logic [31:0] rd;
        logic        prev;
        int          changes;
        bit          found;
        logic [31:0] exp_fall;

        reset     = 1'b1;
        in_port   = 10'h3FF;
        address   = ADDR_DATA;
        write     = 1'b0;
        writedata = '0;
        op_ready  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_readdata", readdata, 32'd0);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_op_valid", 32'(op_valid), 32'd0);
        checkOutput("reset_op_data", 32'(op_data), 32'd0);
        reset = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (readdata == 32'h3FF) found = 1'b1;
        end
        checkOutput("deb_after_reset", readdata, 32'h3FF);
        repeat (2) @(negedge clk);
        checkOutput("boot_op_valid", 32'(op_valid), 32'd1);
        checkOutput("boot_op_data", 32'(op_data), 32'h1FF);
        ready_pulse("boot_release");

        applyStimulus(10'h000, SETTLE);
        bus_write(ADDR_EDGE, 32'h3FF);
        bus_read(ADDR_EDGE, rd);
        checkOutput("edge_cleared", rd, 32'd0);

        // Bounce on bit 0: toggles every 3 cycles never give 4 equal samples.
        address = ADDR_DATA;
        @(negedge clk);
        prev    = readdata[0];
        changes = 0;
        for (int c = 0; c < 60; c++) begin
            in_port[0] = (c < 30) ? (((c / 3) % 2) == 0) : 1'b1;
            @(negedge clk);
            if (readdata[0] != prev) changes++;
            prev = readdata[0];
        end
        checkOutput("bounce_changes", 32'(changes), 32'd1);
        bus_read(ADDR_EDGE, rd);
        checkOutput("bounce_edge", rd, 32'h001);
        bus_write(ADDR_MASK, 32'h001);
        checkOutput("irq_set", 32'(irq), 32'd1);
        bus_write(ADDR_EDGE, 32'h001);
        checkOutput("irq_cleared", 32'(irq), 32'd0);
        bus_read(ADDR_MASK, rd);
        checkOutput("mask_read", rd, 32'h001);

        // Launch with operand 0x155 and hold it while the accelerator stalls.
        applyStimulus(10'h155, SETTLE);
        applyStimulus(10'h355, SETTLE);
        checkOutput("launch_valid", 32'(op_valid), 32'd1);
        checkOutput("launch_data", 32'(op_data), 32'h155);
        checkOutput("launch_irq_masked", 32'(irq), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("hold_valid", 32'(op_valid), 32'd1);
        checkOutput("hold_data", 32'(op_data), 32'h155);
        bus_read(ADDR_STATUS, rd);
        checkOutput("status_pend", rd, 32'h1);
        ready_pulse("launch_release");

        // Overflow: second GO rise while pending keeps the first operand.
        applyStimulus(10'h155, SETTLE);
        applyStimulus(10'h2AA, SETTLE);
        checkOutput("launch2_data", 32'(op_data), 32'h0AA);
        applyStimulus(10'h0F0, SETTLE);
        applyStimulus(10'h2F0, SETTLE);
        bus_read(ADDR_STATUS, rd);
        checkOutput("status_overflow", rd, 32'h3);
        checkOutput("ovf_data_kept", 32'(op_data), 32'h0AA);
        bus_write(ADDR_STATUS, 32'h2);
        bus_read(ADDR_STATUS, rd);
        checkOutput("ovf_cleared", rd, 32'h1);
        ready_pulse("ovf_release");
        bus_read(ADDR_STATUS, rd);
        checkOutput("status_idle", rd, 32'h0);

        // Collision: W1C on the same edge as edge_capture[4] sets.
        applyStimulus(10'h000, SETTLE);
        bus_write(ADDR_EDGE, 32'h3FF);
        timed_change(10'h010, ADDR_EDGE, 32'h010);
        bus_read(ADDR_EDGE, rd);
        checkOutput("edge_set_wins", rd, 32'h010);

        // Collision: overflow clear on the same edge as a pending GO rise.
        applyStimulus(10'h200, SETTLE);
        checkOutput("collide_launch", 32'(op_valid), 32'd1);
        applyStimulus(10'h000, SETTLE);
        timed_change(10'h200, ADDR_STATUS, 32'h2);
        bus_read(ADDR_STATUS, rd);
        checkOutput("ovf_set_wins", rd, 32'h3);
        ready_pulse("collide_release");

        // Falling edge on deb[2].
        applyStimulus(10'h004, SETTLE);
        bus_write(ADDR_EDGE, 32'h3FF);
        applyStimulus(10'h000, SETTLE);
`ifdef SW_BOTH_EDGES_EN
        exp_fall = 32'h004;
`else
        exp_fall = 32'h000;
`endif
        bus_read(ADDR_EDGE, rd);
        checkOutput("fall_edge", rd, exp_fall);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
